// File: rtl/svm_pkg.sv
// Shared types and helpers for the sampled-value monitor.
//   svm_mode_e    : expectation checked on each sample (CHANGED/STABLE/ROSE/FELL)
//   svm_state_e   : monitor FSM states (WARMUP/CHECK/HALT)
//   svm_expect_ok : 1 when the sampled-value flags satisfy the selected expectation
package svm_pkg;

    typedef enum logic [1:0] {
        CHANGED = 2'd0,
        STABLE  = 2'd1,
        ROSE    = 2'd2,
        FELL    = 2'd3
    } svm_mode_e;

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        CHECK  = 2'd1,
        HALT   = 2'd2
    } svm_state_e;

    function automatic logic svm_expect_ok(input svm_mode_e mode,
                                           input logic      stable,
                                           input logic      rose,
                                           input logic      fell);
        logic ok;
        case (mode)
            STABLE:  ok = stable;
            ROSE:    ok = rose;
            FELL:    ok = fell;
            default: ok = !stable;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/svm_history.sv
// Enabled sample history for the sampled-value monitor.
// Stage 0 holds the most recent sample; stage DEPTH holds the sample taken
// DEPTH enabled samples before it. A saturating sample counter qualifies
// past_val.
//   clk, rst    : clock, synchronous active-high reset
//   sample      : capture din this edge and shift the history
//   clear       : forget all samples (count and past_valid to 0)
//   din         : value to capture
//   prev        : most recent stored sample (s_{k-1} relative to din)
//   past_val    : sample DEPTH samples older than the most recent one
//   past_valid  : past_val holds a real sample
module svm_history #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] prev,
    output logic [WIDTH-1:0] past_val,
    output logic             past_valid
);

    localparam int            NW      = $clog2(DEPTH + 2);
    localparam logic [NW-1:0] N_MAX   = NW'(DEPTH + 1);
    localparam logic [NW-1:0] N_DEPTH = NW'(DEPTH);

    logic [WIDTH-1:0] hist [DEPTH+1];
    logic [NW-1:0]    n_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= DEPTH; i++) hist[i] <= '0;
            n_q        <= '0;
            past_valid <= 1'b0;
        end else if (clear) begin
            // History contents are left alone; the count alone decides validity.
            n_q        <= '0;
            past_valid <= 1'b0;
        end else if (sample) begin
            hist[0] <= din;
            for (int i = 1; i <= DEPTH; i++) hist[i] <= hist[i-1];
            if (n_q != N_MAX) n_q <= n_q + NW'(1);
            // After this sample the count is n_q+1; valid once it exceeds DEPTH.
            past_valid <= (n_q >= N_DEPTH);
        end
    end

    assign prev     = hist[0];
    assign past_val = hist[DEPTH];

endmodule

// File: rtl/sampled_value_monitor.sv
// Sampled-value checker: registered RTL equivalents of $stable/$changed/
// $rose/$fell/$past on val, a selectable expectation check, and failure
// bookkeeping (saturating count, cycle of first failure).
//   clk, rst                     : clock, synchronous active-high reset
//   en                           : sampling enable; low restarts warm-up
//   mode                         : expectation (svm_mode_e encoding)
//   val                          : monitored value
//   stable/changed/rose/fell     : flags for the latest sample
//   past_val, past_valid         : sample DEPTH samples ago and its qualifier
//   fail                         : one-cycle pulse on a violated expectation
//   halted                       : monitor stopped after a failure
//   fail_count, first_fail_cyc   : failure count and cyc of first failure
//   cyc                          : free-running cycle count since reset
//   state                        : FSM state, exported for observation
// en is a level-qualified sample strobe: a sample is taken on every rising
// edge where en is high and the monitor is not halted. There is no back-pressure.
module sampled_value_monitor
    import svm_pkg::*;
#(
    parameter int WIDTH        = 1,
    parameter int DEPTH        = 4,
    parameter int CNT_W        = 32,
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] val,
    output logic             stable,
    output logic             changed,
    output logic             rose,
    output logic             fell,
    output logic [WIDTH-1:0] past_val,
    output logic             past_valid,
    output logic             fail,
    output logic             halted,
    output logic [CNT_W-1:0] fail_count,
    output logic [CNT_W-1:0] first_fail_cyc,
    output logic [CNT_W-1:0] cyc,
    output svm_state_e       state
);

    svm_state_e       state_q, state_d;
    logic             sample, clear;
    logic [WIDTH-1:0] prev;
    logic             cur_stable, cur_rose, cur_fell, violation;

    svm_history #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_history (
        .clk        (clk),
        .rst        (rst),
        .sample     (sample),
        .clear      (clear),
        .din        (val),
        .prev       (prev),
        .past_val   (past_val),
        .past_valid (past_valid)
    );

    // Next state and the combinational view of the sample on this edge.
    always_comb begin
        sample     = en && (state_q != HALT);
        clear      = !en && (state_q != HALT);
        cur_stable = (val == prev);
        cur_rose   = val[0] & ~prev[0];
        cur_fell   = ~val[0] & prev[0];
        // Only CHECK has a valid previous sample; en low means no sample at all.
        violation  = (state_q == CHECK) && en &&
                     !svm_expect_ok(svm_mode_e'(mode), cur_stable, cur_rose, cur_fell);
        state_d    = state_q;
        case (state_q)
            WARMUP:  if (en) state_d = CHECK;
            CHECK: begin
                if (!en)                            state_d = WARMUP;
                else if (violation && STOP_ON_FAIL) state_d = HALT;
            end
            HALT:    state_d = HALT;
            default: state_d = WARMUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= WARMUP;
            halted         <= 1'b0;
            stable         <= 1'b0;
            changed        <= 1'b0;
            rose           <= 1'b0;
            fell           <= 1'b0;
            fail           <= 1'b0;
            fail_count     <= '0;
            first_fail_cyc <= '0;
            cyc            <= '0;
        end else begin
            state_q <= state_d;
            halted  <= (state_d == HALT);
            cyc     <= cyc + CNT_W'(1);
            fail    <= violation;
            if (violation) begin
                if (fail_count != '1) fail_count <= fail_count + CNT_W'(1);
                if (fail_count == '0) first_fail_cyc <= cyc;
            end
            // Flags freeze in HALT; otherwise they describe the sample just taken.
            if (state_q != HALT) begin
                if (en && state_q == CHECK) begin
                    stable  <= cur_stable;
                    changed <= !cur_stable;
                    rose    <= cur_rose;
                    fell    <= cur_fell;
                end else begin
                    stable  <= 1'b0;
                    changed <= 1'b0;
                    rose    <= 1'b0;
                    fell    <= 1'b0;
                end
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_sampled_value_monitor.sv
module tb_sampled_value_monitor;
    import svm_pkg::*;

    // ---------------- clock / reset / shared stimulus ----------------
    logic       clk = 1'b0;
    logic       rst, en;
    logic [1:0] mode;
    logic       val1;
    logic [2:0] val3;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int tb_cyc   = 0;
    logic exp_q[$];

    // dut a: WIDTH=1, STOP_ON_FAIL=1
    logic a_stable, a_changed, a_rose, a_fell, a_past_val, a_past_valid, a_fail, a_halted;
    logic [31:0] a_fail_count, a_first_fail_cyc, a_cyc;
    svm_state_e a_state;
    // dut b: WIDTH=3, STOP_ON_FAIL=1
    logic b_stable, b_changed, b_rose, b_fell, b_past_valid, b_fail, b_halted;
    logic [2:0] b_past_val;
    logic [31:0] b_fail_count, b_first_fail_cyc, b_cyc;
    svm_state_e b_state;
    // dut c: WIDTH=1, STOP_ON_FAIL=0
    logic c_stable, c_changed, c_rose, c_fell, c_past_val, c_past_valid, c_fail, c_halted;
    logic [31:0] c_fail_count, c_first_fail_cyc, c_cyc;
    svm_state_e c_state;

    sampled_value_monitor #(.WIDTH(1), .DEPTH(4), .CNT_W(32), .STOP_ON_FAIL(1'b1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .val(val1),
        .stable(a_stable), .changed(a_changed), .rose(a_rose), .fell(a_fell),
        .past_val(a_past_val), .past_valid(a_past_valid), .fail(a_fail), .halted(a_halted),
        .fail_count(a_fail_count), .first_fail_cyc(a_first_fail_cyc), .cyc(a_cyc), .state(a_state));

    sampled_value_monitor #(.WIDTH(3), .DEPTH(4), .CNT_W(32), .STOP_ON_FAIL(1'b1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .val(val3),
        .stable(b_stable), .changed(b_changed), .rose(b_rose), .fell(b_fell),
        .past_val(b_past_val), .past_valid(b_past_valid), .fail(b_fail), .halted(b_halted),
        .fail_count(b_fail_count), .first_fail_cyc(b_first_fail_cyc), .cyc(b_cyc), .state(b_state));

    sampled_value_monitor #(.WIDTH(1), .DEPTH(4), .CNT_W(32), .STOP_ON_FAIL(1'b0)) dut_c (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .val(val1),
        .stable(c_stable), .changed(c_changed), .rose(c_rose), .fell(c_fell),
        .past_val(c_past_val), .past_valid(c_past_valid), .fail(c_fail), .halted(c_halted),
        .fail_count(c_fail_count), .first_fail_cyc(c_first_fail_cyc), .cyc(c_cyc), .state(c_state));

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        tb_cyc++;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        en   = 1'b0;
        mode = 2'd0;
        val1 = 1'b0;
        val3 = 3'd0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        tb_cyc = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({a_stable, a_changed, a_rose, a_fell} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b exp 0000", {a_stable, a_changed, a_rose, a_fell});
        end
        n_checks++;
        if ({a_past_val, a_past_valid, a_fail, a_halted} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_misc: got %b exp 0000", {a_past_val, a_past_valid, a_fail, a_halted});
        end
        n_checks++;
        if (a_fail_count !== 32'd0 || a_first_fail_cyc !== 32'd0 || a_cyc !== 32'd0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d/%0d exp 0/0/0", a_fail_count, a_first_fail_cyc, a_cyc);
        end
        n_checks++;
        if (a_state !== WARMUP) begin
            n_fail++; $display("FAIL reset_state: got %0d exp %0d", a_state, WARMUP);
        end
    endtask

    task automatic test_changed();
        logic [3:0] exp_flags;
        logic       v;
        do_reset();
        mode = 2'd0;
        en   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            v    = 1'(i % 2);
            val1 = v;
            step();
            // order: stable, changed, rose, fell
            exp_flags = (i == 0) ? 4'b0000 : {1'b0, 1'b1, v, ~v};
            n_checks++;
            if ({a_stable, a_changed, a_rose, a_fell} !== exp_flags) begin
                n_fail++; $display("FAIL chg_flags[%0d]: got %b exp %b", i, {a_stable, a_changed, a_rose, a_fell}, exp_flags);
            end
            n_checks++;
            if (a_fail !== 1'b0) begin
                n_fail++; $display("FAIL chg_fail[%0d]: got %b exp 0", i, a_fail);
            end
        end
        n_checks++;
        if (a_fail_count !== 32'd0 || a_cyc !== 32'(tb_cyc)) begin
            n_fail++; $display("FAIL chg_end: count %0d cyc %0d exp 0 %0d", a_fail_count, a_cyc, tb_cyc);
        end
    endtask

    task automatic test_stable_stop();
        int exp_first;
        exp_first = -1;
        do_reset();
        mode = 2'd1;
        en   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            val1 = 1'(i % 2);
            if (i == 1) exp_first = tb_cyc;
            step();
            n_checks++;
            if (a_fail !== (i == 1)) begin
                n_fail++; $display("FAIL stop_fail[%0d]: got %b exp %b", i, a_fail, (i == 1));
            end
            n_checks++;
            if (a_halted !== (i >= 1)) begin
                n_fail++; $display("FAIL stop_halted[%0d]: got %b exp %b", i, a_halted, (i >= 1));
            end
        end
        n_checks++;
        if (a_first_fail_cyc !== 32'(exp_first) || a_fail_count !== 32'd1) begin
            n_fail++; $display("FAIL stop_counts: first %0d count %0d exp %0d 1", a_first_fail_cyc, a_fail_count, exp_first);
        end
        n_checks++;
        if ({a_stable, a_changed, a_rose, a_fell} !== 4'b0110 || a_state !== HALT) begin
            n_fail++; $display("FAIL stop_frozen: flags %b state %0d exp 0110 %0d", {a_stable, a_changed, a_rose, a_fell}, a_state, HALT);
        end
        n_checks++;
        if (a_cyc !== 32'(tb_cyc)) begin
            n_fail++; $display("FAIL stop_cyc: got %0d exp %0d", a_cyc, tb_cyc);
        end
    endtask

    task automatic test_past_valid();
        logic [2:0] exp_pv;
        do_reset();
        mode = 2'd1;
        en   = 1'b1;
        val3 = 3'b101;
        for (int j = 1; j <= 8; j++) begin
            step();
            exp_pv = (j >= 5) ? 3'b101 : 3'b000;
            n_checks++;
            if (b_past_valid !== (j >= 5) || b_past_val !== exp_pv) begin
                n_fail++; $display("FAIL past[%0d]: valid %b val %b exp %b %b", j, b_past_valid, b_past_val, (j >= 5), exp_pv);
            end
            n_checks++;
            if (b_fail !== 1'b0 || b_stable !== (j >= 2)) begin
                n_fail++; $display("FAIL past_chk[%0d]: fail %b stable %b exp 0 %b", j, b_fail, b_stable, (j >= 2));
            end
        end
    endtask

    task automatic test_rose_nostop();
        logic e;
        do_reset();
        mode = 2'd2;
        en   = 1'b1;
        for (int i = 0; i < 11; i++) exp_q.push_back((i >= 2) && (i % 2 == 0));
        for (int i = 0; i < 11; i++) begin
            val1 = 1'(i % 2);
            step();
            e = exp_q.pop_front();
            n_checks++;
            if (c_fail !== e) begin
                n_fail++; $display("FAIL rose_fail[%0d]: got %b exp %b", i, c_fail, e);
            end
            if (i >= 2) begin
                n_checks++;
                if (c_first_fail_cyc !== 32'd2) begin
                    n_fail++; $display("FAIL rose_first[%0d]: got %0d exp 2", i, c_first_fail_cyc);
                end
            end
        end
        n_checks++;
        if (c_fail_count !== 32'd5 || c_halted !== 1'b0) begin
            n_fail++; $display("FAIL rose_end: count %0d halted %b exp 5 0", c_fail_count, c_halted);
        end
    endtask

    task automatic test_en_gap();
        do_reset();
        mode = 2'd1;
        en   = 1'b1;
        val1 = 1'b0;
        for (int i = 0; i < 6; i++) step();
        n_checks++;
        if (a_past_valid !== 1'b1) begin
            n_fail++; $display("FAIL gap_pv_pre: got %b exp 1", a_past_valid);
        end
        en   = 1'b0;
        val1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (a_past_valid !== 1'b0 || a_fail !== 1'b0 || a_state !== WARMUP ||
                {a_stable, a_changed, a_rose, a_fell} !== 4'b0000) begin
                n_fail++; $display("FAIL gap_off[%0d]: pv %b fail %b state %0d flags %b exp 0 0 %0d 0000",
                                   i, a_past_valid, a_fail, a_state, {a_stable, a_changed, a_rose, a_fell}, WARMUP);
            end
        end
        en = 1'b1;
        step();
        n_checks++;
        if (a_fail !== 1'b0 || a_state !== CHECK || a_past_valid !== 1'b0 ||
            {a_stable, a_changed, a_rose, a_fell} !== 4'b0000) begin
            n_fail++; $display("FAIL gap_reen: fail %b state %0d pv %b flags %b exp 0 %0d 0 0000",
                               a_fail, a_state, a_past_valid, {a_stable, a_changed, a_rose, a_fell}, CHECK);
        end
        step();
        n_checks++;
        if (a_fail !== 1'b0 || {a_stable, a_changed, a_rose, a_fell} !== 4'b1000) begin
            n_fail++; $display("FAIL gap_second: fail %b flags %b exp 0 1000", a_fail, {a_stable, a_changed, a_rose, a_fell});
        end
        val1 = 1'b0;
        step();
        n_checks++;
        if (a_fail !== 1'b1 || a_halted !== 1'b1 || a_fail_count !== 32'd1) begin
            n_fail++; $display("FAIL gap_viol: fail %b halted %b count %0d exp 1 1 1", a_fail, a_halted, a_fail_count);
        end
    endtask

    task automatic test_mode_switch();
        logic [1:0] modes [4];
        logic       vals  [4];
        logic       fails [4];
        modes = '{2'd2, 2'd1, 2'd3, 2'd0};
        vals  = '{1'b1, 1'b1, 1'b0, 1'b0};
        fails = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        en   = 1'b1;
        val1 = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            mode = modes[i];
            val1 = vals[i];
            step();
            n_checks++;
            if (c_fail !== fails[i]) begin
                n_fail++; $display("FAIL mode_sw[%0d]: got %b exp %b", i, c_fail, fails[i]);
            end
        end
    endtask

    task automatic test_halt_reset();
        n_checks++;
        if (a_halted !== 1'b1) begin
            n_fail++; $display("FAIL hr_pre: halted %b exp 1", a_halted);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (a_state !== WARMUP || a_halted !== 1'b0 || a_cyc !== 32'd0 || a_fail_count !== 32'd0 ||
            a_first_fail_cyc !== 32'd0 || a_fail !== 1'b0 || a_past_valid !== 1'b0 || a_past_val !== 1'b0 ||
            {a_stable, a_changed, a_rose, a_fell} !== 4'b0000) begin
            n_fail++; $display("FAIL hr_post: state %0d halted %b cyc %0d cnt %0d first %0d fail %b pv %b pval %b flags %b",
                               a_state, a_halted, a_cyc, a_fail_count, a_first_fail_cyc, a_fail, a_past_valid,
                               a_past_val, {a_stable, a_changed, a_rose, a_fell});
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_changed();
        test_stable_stop();
        test_past_valid();
        test_rose_nostop();
        test_mode_switch();
        test_en_gap();
        test_halt_reset();
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
